// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: denomination values, one-hot order and
// payout FSM state encodings.
package vm_pkg;

  localparam int NUM_DENOM   = 5;
  localparam int AMT_W       = 8;
  localparam int STOCK_W_DEF = 4;

  // Bit order used everywhere: [4]=50 [3]=20 [2]=10 [1]=5 [0]=1
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_DISPENSE = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_FINISH   = 3'd4;
  localparam logic [2:0] ST_FAIL     = 3'd5;

  function automatic logic [AMT_W-1:0] denom_value(input int idx);
    case (idx)
      0:       return 8'd1;
      1:       return 8'd5;
      2:       return 8'd10;
      3:       return 8'd20;
      4:       return 8'd50;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [NUM_DENOM-1:0] denom_onehot(input int idx);
    return NUM_DENOM'(1) << idx;
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Payout control/status bundle between the transaction logic and the change
// dispenser controller.
interface change_dispense_ctrl_if;
  import vm_pkg::*;

  logic                 start;
  logic [AMT_W-1:0]     change_amt;
  logic                 refill;
  // disp_req rises with disp_sel already stable and holds until disp_ack is
  // seen high on a clock edge; disp_ack in any other cycle is ignored.
  logic                 disp_ack;
  logic                 disp_req;
  logic [NUM_DENOM-1:0] disp_sel;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [AMT_W-1:0]     remaining;
  logic [NUM_DENOM-1:0] stock_empty;
  logic [2:0]           dbg_state;

  modport master (
    output start, change_amt, refill, disp_ack,
    input  disp_req, disp_sel, busy, done, error, remaining, stock_empty,
           dbg_state
  );

  modport slave (
    input  start, change_amt, refill, disp_ack,
    output disp_req, disp_sel, busy, done, error, remaining, stock_empty,
           dbg_state
  );
endinterface

// File: rtl/denom_select.sv
// Greedy denomination picker: largest denomination not above the amount owed
// whose stock is not empty.
module denom_select
  import vm_pkg::*;
(
  input  logic [AMT_W-1:0]     i_remaining,
  input  logic [NUM_DENOM-1:0] i_stock_empty,
  output logic [NUM_DENOM-1:0] o_onehot,
  output logic [AMT_W-1:0]     o_value,
  output logic                 o_found
);

  always_comb begin
    o_onehot = '0;
    o_value  = '0;
    o_found  = 1'b0;
    for (int i = NUM_DENOM - 1; i >= 0; i--) begin
      if (!o_found && !i_stock_empty[i] && (denom_value(i) <= i_remaining)) begin
        o_onehot = denom_onehot(i);
        o_value  = denom_value(i);
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: issues one note at a time over req/ack using greedy
// selection bounded by stock. Define CHANGE_TIMEOUT_EN to abort on a stuck ack.
module change_dispense_ctrl
  import vm_pkg::*;
#(
  parameter int INIT_STOCK  = 8,
  parameter int STOCK_W     = STOCK_W_DEF,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  change_dispense_ctrl_if.slave  bus
);

  // One counter serves both the inter-note gap and the ack timeout.
  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]           r_state;
  logic [AMT_W-1:0]     r_remaining;
  logic [NUM_DENOM-1:0] r_sel;
  logic [AMT_W-1:0]     r_val;
  logic [CNT_W-1:0]     r_cnt;
  logic [STOCK_W-1:0]   r_stock [NUM_DENOM];

  logic [NUM_DENOM-1:0] w_empty;
  logic [NUM_DENOM-1:0] w_pick_oh;
  logic [AMT_W-1:0]     w_pick_val;
  logic                 w_found;

  always_comb begin
    w_empty = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      w_empty[i] = (r_stock[i] == '0);
    end
  end

  denom_select u_denom_select (
    .i_remaining   (r_remaining),
    .i_stock_empty (w_empty),
    .o_onehot      (w_pick_oh),
    .o_value       (w_pick_val),
    .o_found       (w_found)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_sel       <= '0;
      r_val       <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < NUM_DENOM; i++) begin
        r_stock[i] <= STOCK_W'(INIT_STOCK);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_remaining <= bus.change_amt;
            r_state     <= ST_SELECT;
          end
          if (bus.refill) begin
            for (int i = 0; i < NUM_DENOM; i++) begin
              r_stock[i] <= STOCK_W'(INIT_STOCK);
            end
          end
        end
        ST_SELECT: begin
          if (r_remaining == '0) begin
            r_state <= ST_FINISH;
          end else if (w_found) begin
            r_sel   <= w_pick_oh;
            r_val   <= w_pick_val;
            r_cnt   <= '0;
            r_state <= ST_DISPENSE;
          end else begin
            r_state <= ST_FAIL;
          end
        end
        ST_DISPENSE: begin
          if (bus.disp_ack) begin
            r_remaining <= r_remaining - r_val;
            for (int i = 0; i < NUM_DENOM; i++) begin
              if (r_sel[i] && (r_stock[i] != '0)) begin
                r_stock[i] <= r_stock[i] - STOCK_W'(1);
              end
            end
            r_sel   <= '0;
            r_cnt   <= '0;
            r_state <= ST_GAP;
          end
`ifdef CHANGE_TIMEOUT_EN
          // Abandon the note without touching stock or the amount owed.
          else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            r_sel   <= '0;
            r_state <= ST_FAIL;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`else
`endif
        end
        ST_GAP: begin
          if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
            r_state <= ST_SELECT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FINISH: r_state <= ST_IDLE;
        ST_FAIL:   r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.disp_req    = (r_state == ST_DISPENSE);
  assign bus.disp_sel    = r_sel;
  assign bus.busy        = (r_state == ST_SELECT) || (r_state == ST_DISPENSE) ||
                           (r_state == ST_GAP);
  assign bus.done        = (r_state == ST_FINISH);
  assign bus.error       = (r_state == ST_FAIL);
  assign bus.remaining   = r_remaining;
  assign bus.stock_empty = w_empty;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: directed payouts, a vector table and random
// payouts checked against a greedy payout model.
module tb_change_dispense_ctrl;

  localparam int INIT_STOCK = 8;
  localparam int GAP        = 4;
  localparam int ACK_TO     = 10;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  change_dispense_ctrl_if u_if ();

  change_dispense_ctrl #(
    .INIT_STOCK  (INIT_STOCK),
    .STOCK_W     (4),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ACK_TO)
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (u_if)
  );

  always #5 sys_clk = ~sys_clk;

  int         n_checks = 0;
  int         n_err    = 0;
  int         m_stock [5];
  int         dv [5] = '{1, 5, 10, 20, 50};
  logic [4:0] exp_q [$];
  int         exp_rem;
  bit         exp_err;

  typedef struct {
    logic [7:0] amt;
    int         notes;
    logic       err;
    logic [7:0] rem;
  } vec_t;
  vec_t tbl [8];

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic void model_reload();
    for (int i = 0; i < 5; i++) m_stock[i] = INIT_STOCK;
  endfunction

  function automatic logic [4:0] model_empty();
    logic [4:0] e;
    for (int i = 0; i < 5; i++) e[i] = (m_stock[i] == 0);
    return e;
  endfunction

  // Greedy payout: repeatedly take the largest stocked coin not above the debt.
  function automatic void model_pay(input int amt);
    int rem;
    int pick;
    logic [4:0] oh;
    rem = amt;
    exp_err = 1'b0;
    exp_q.delete();
    while (rem > 0) begin
      pick = -1;
      for (int i = 4; i >= 0; i--) begin
        if (pick < 0 && dv[i] <= rem && m_stock[i] > 0) pick = i;
      end
      if (pick < 0) begin
        exp_err = 1'b1;
        break;
      end
      oh = '0;
      oh[pick] = 1'b1;
      exp_q.push_back(oh);
      rem -= dv[pick];
      m_stock[pick]--;
    end
    exp_rem = rem;
  endfunction

  task automatic do_refill();
    u_if.refill = 1'b1;
    tick();
    u_if.refill = 1'b0;
    model_reload();
  endtask

  task automatic pay(input int amt, input int max_delay, input bit refill_mid,
                     output int n_notes, output bit o_err, output logic [7:0] o_rem);
    int low_cnt, wait_cnt, delay, n;
    bit seen, first, fin;
    logic [4:0] exp_sel;
    string lname;
    model_pay(amt);
    u_if.change_amt = amt[7:0];
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    chk("busy_after_start", u_if.busy, 1);
    low_cnt = 0; wait_cnt = 0; delay = 0; n = 0; seen = 0; first = 1; fin = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      u_if.disp_ack = 1'b0;
      if (u_if.done || u_if.error) begin
        fin = 1;
        break;
      end
      if (u_if.disp_req) begin
        if (!seen) begin
          if (first) begin
            lname = "first_req_latency";
            chk(lname, low_cnt, 1);
          end else begin
            lname = "gap_latency";
            chk(lname, low_cnt, GAP + 1);
          end
          seen = 1; first = 0; wait_cnt = 0;
          delay = $urandom_range(0, max_delay);
        end
        if (wait_cnt == delay) begin
          exp_sel = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b0;
          chk("disp_sel", u_if.disp_sel, exp_sel);
          n++;
          u_if.disp_ack = 1'b1;
          seen = 0;
          low_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        low_cnt++;
      end
      if (refill_mid && cyc == 0) u_if.refill = 1'b1;
      tick();
      u_if.refill = 1'b0;
    end
    u_if.disp_ack = 1'b0;
    chk("finished_in_bound", fin, 1);
    chk("done", u_if.done, !exp_err);
    chk("error", u_if.error, exp_err);
    chk("busy_at_end", u_if.busy, 0);
    chk("remaining", u_if.remaining, exp_rem);
    chk("notes_left", exp_q.size(), 0);
    chk("stock_empty", u_if.stock_empty, model_empty());
    o_err = u_if.error;
    tick();
    chk("pulse_cleared", {u_if.done, u_if.error, u_if.busy}, 0);
    o_rem = u_if.remaining;
    n_notes = n;
  endtask

  initial begin
    int n, cnt;
    bit e, got;
    logic [7:0] r;

    tbl[0] = '{8'd37,  5, 1'b0, 8'd0};
    tbl[1] = '{8'd0,   0, 1'b0, 8'd0};
    tbl[2] = '{8'd1,   1, 1'b0, 8'd0};
    tbl[3] = '{8'd255, 6, 1'b0, 8'd0};
    tbl[4] = '{8'd99,  8, 1'b0, 8'd0};
    tbl[5] = '{8'd88,  7, 1'b0, 8'd0};
    tbl[6] = '{8'd4,   4, 1'b0, 8'd0};
    tbl[7] = '{8'd45,  3, 1'b0, 8'd0};

    u_if.start = 1'b0; u_if.change_amt = '0; u_if.refill = 1'b0; u_if.disp_ack = 1'b0;
    model_reload();
    repeat (3) tick();
    chk("rst_disp_req", u_if.disp_req, 0);
    chk("rst_disp_sel", u_if.disp_sel, 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_error", u_if.error, 0);
    chk("rst_remaining", u_if.remaining, 0);
    chk("rst_stock_empty", u_if.stock_empty, 0);
    sys_rst_n = 1'b1;
    tick();

    // Full stock, 37 -> 20,10,5,1,1
    pay(37, 2, 0, n, e, r);
    chk("t1_notes", n, 5);

    // Reset while a request is outstanding
    u_if.change_amt = 8'd37;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_if.disp_req) begin
        got = 1;
        break;
      end
      tick();
    end
    chk("t5_req_seen", got, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t5_req_drop", u_if.disp_req, 0);
    chk("t5_busy_drop", u_if.busy, 0);
    chk("t5_sel_drop", u_if.disp_sel, 0);
    tick();
    sys_rst_n = 1'b1;
    model_reload();
    exp_q.delete();
    tick();
    chk("t5_busy_after", u_if.busy, 0);
    chk("t5_stock_after", u_if.stock_empty, 0);

    // Drain 50s and 20s, then 40 with a refill attempt while busy
    pay(250, 1, 0, n, e, r);
    pay(250, 1, 0, n, e, r);
    pay(60, 1, 0, n, e, r);
    chk("t2_drained", u_if.stock_empty, 5'b11000);
    pay(40, 1, 1, n, e, r);
    chk("t2_notes", n, 4);
    chk("t2_empty_hi", u_if.stock_empty[4:3], 2'b11);

    // Only two 1s left, ask for 3
    pay(80, 0, 0, n, e, r);
    chk("t3_drained", u_if.stock_empty, 5'b11110);
    pay(6, 0, 0, n, e, r);
    pay(3, 1, 0, n, e, r);
    chk("t3_notes", n, 2);
    chk("t3_error", e, 1);
    chk("t3_shortfall", r, 1);

    // Zero amount
    u_if.change_amt = 8'd0;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    chk("t4_busy", u_if.busy, 1);
    chk("t4_done_early", u_if.done, 0);
    chk("t4_req0", u_if.disp_req, 0);
    tick();
    chk("t4_done", u_if.done, 1);
    chk("t4_req1", u_if.disp_req, 0);
    chk("t4_busy_off", u_if.busy, 0);
    tick();
    chk("t4_done_clr", u_if.done, 0);

    for (int i = 0; i < 8; i++) begin
      do_refill();
      pay(int'(tbl[i].amt), 2, 0, n, e, r);
      chk("tbl_notes", n, tbl[i].notes);
      chk("tbl_err", e, tbl[i].err);
      chk("tbl_rem", r, tbl[i].rem);
    end

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) do_refill();
      pay(int'($urandom_range(0, 120)), 3, 1'($urandom_range(0, 1)), n, e, r);
    end

`ifdef CHANGE_TIMEOUT_EN
    do_refill();
    u_if.change_amt = 8'd5;
    u_if.start = 1'b1;
    tick();
    u_if.start = 1'b0;
    cnt = 0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      if (u_if.error) begin
        got = 1;
        break;
      end
      if (u_if.disp_req) cnt++;
      tick();
    end
    chk("t6_error_seen", got, 1);
    chk("t6_req_cycles", cnt, ACK_TO);
    chk("t6_remaining", u_if.remaining, 5);
    chk("t6_req_drop", u_if.disp_req, 0);
    tick();
    pay(5, 0, 0, n, e, r);
    chk("t6_retry_notes", n, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
